fir_stream_core: RTL and testbench

FIR_STREAM_CORE -- requirements
Module: fir_stream_core

---
 rtl/fir_stream_core.sv | 123 ++++++++++++
 tb/tb_fir_stream_core.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fir_stream_core.sv
// fir_stream_core: streaming FIR with shadow/active coefficient banks, registered adder tree, rounding and saturation
// Ports: clk, rst_n (async, active low) | s_valid/s_data: input samples
//        coef_we/coef_addr/coef_wdata: shadow bank writes | coef_commit: request shadow->active copy
//        clear: sync flush | m_valid/m_data: filtered output | sat_flag: sticky saturation | commit_busy: copy pending
module fir_stream_core #(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int TAPS    = 33,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 15,
  parameter int ADD_GRP = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  input  logic                     coef_commit,
  input  logic                     clear,
  output logic                     m_valid,
  output logic [OUT_W-1:0]         m_data,
  output logic                     sat_flag,
  output logic                     commit_busy
);
  localparam int AW = DATA_W + COEF_W + $clog2(TAPS);

  function automatic int lvl_cnt(int l);
    int n = TAPS;
    for (int i = 0; i < l; i++) n = (n + ADD_GRP - 1) / ADD_GRP;
    return n;
  endfunction

  function automatic int num_lv();
    int l = 0;
    for (int i = 1; i < 8; i++) if (lvl_cnt(i - 1) > 1) l = i;
    return l;
  endfunction

  localparam int LV  = num_lv();
  localparam int LAT = LV + 3;
  localparam logic signed [AW-1:0] RND  = (AW'(1) << SHIFT) >> 1;
  localparam logic signed [AW-1:0] MAXV = (AW'(1) << (OUT_W - 1)) - AW'(1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic {IDLE, PEND} st_t;
  st_t st, st_nxt;
  logic copy;

  logic signed [COEF_W-1:0] c_sh [0:TAPS-1];
  logic signed [COEF_W-1:0] c_act [0:TAPS-1];
  logic signed [DATA_W-1:0] x [0:TAPS-1];
  // level 0 holds the products, level l the registered partial sums of level l-1
  logic signed [AW-1:0] lvl [0:LV][0:TAPS-1];
  logic signed [AW-1:0] sum [1:LV][0:TAPS-1];
  logic signed [AW-1:0] acc, rnd, sh;
  logic [LAT-1:0] v;
  logic o_sat;
  logic [OUT_W-1:0] o_val;

  // the copy fires on the same edge that accepts the sample, so that sample sees the new bank
  always_comb begin
    copy   = (st == PEND) & s_valid;
    st_nxt = copy ? IDLE : coef_commit ? PEND : st;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_nxt;

  assign commit_busy = (st == PEND);

  // nonblocking copy reads the shadow value from before a same-cycle write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        c_sh[k]  <= '0;
        c_act[k] <= '0;
      end
    end else begin
      if (copy) for (int k = 0; k < TAPS; k++) c_act[k] <= c_sh[k];
      if (coef_we && int'(coef_addr) < TAPS) c_sh[coef_addr] <= coef_wdata;
    end

  always_comb begin
    acc = '0;
    for (int l = 1; l <= LV; l++)
      for (int j = 0; j < TAPS; j++) begin
        acc = '0;
        for (int k = 0; k < ADD_GRP; k++)
          acc = (j * ADD_GRP + k < lvl_cnt(l - 1)) ? acc + lvl[l-1][j*ADD_GRP+k] : acc;
        sum[l][j] = acc;
      end
  end

  assign sh    = rnd >>> SHIFT;
  assign o_sat = (sh > MAXV) || (sh < MINV);
  assign o_val = (sh > MAXV) ? MAXV[OUT_W-1:0] : (sh < MINV) ? MINV[OUT_W-1:0] : sh[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      for (int l = 0; l <= LV; l++)
        for (int j = 0; j < TAPS; j++) lvl[l][j] <= '0;
      rnd      <= '0;
      v        <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      sat_flag <= 1'b0;
    end else begin
      x[0] <= clear ? '0 : s_valid ? s_data : x[0];
      for (int k = 1; k < TAPS; k++) x[k] <= clear ? '0 : s_valid ? x[k-1] : x[k];
      for (int k = 0; k < TAPS; k++) lvl[0][k] <= clear ? '0 : AW'(x[k]) * AW'(c_act[k]);
      for (int l = 1; l <= LV; l++)
        for (int j = 0; j < TAPS; j++) lvl[l][j] <= clear ? '0 : sum[l][j];
      rnd      <= clear ? '0 : lvl[LV][0] + RND;
      v        <= clear ? '0 : {v[LAT-2:0], s_valid};
      m_valid  <= ~clear & v[LAT-1];
      if (clear || v[LAT-1]) m_data <= clear ? '0 : o_val;
      sat_flag <= ~clear & (sat_flag | (v[LAT-1] & o_sat));
    end
endmodule

// File: tb/tb_fir_stream_core.sv
// tb_fir_stream_core: directed and random stimulus against a direct-convolution reference model
module tb_fir_stream_core;
  localparam int DW = 16, CW = 16, TAPS = 33, OW = 16, SH = 15, GRP = 4, LAT = 6, AD = 6;

  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, coef_we = 1'b0, coef_commit = 1'b0, clear = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [AD-1:0] coef_addr = '0;
  logic [CW-1:0] coef_wdata = '0;
  logic m_valid, sat_flag, commit_busy;
  logic [OW-1:0] m_data;

  fir_stream_core #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .OUT_W(OW), .SHIFT(SH), .ADD_GRP(GRP)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_commit(coef_commit), .clear(clear),
    .m_valid(m_valid), .m_data(m_data), .sat_flag(sat_flag), .commit_busy(commit_busy)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int val; bit sat;} exp_t;
  exp_t q[$];
  int shd[TAPS], act[TAPS], xl[TAPS];
  bit pend, sat_m;
  int last, cyc, n_cmp, n_err;

  task automatic chk(string tag, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic exp_t filt();
    longint acc = 0, y, hi, lo;
    exp_t e;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -hi - 1;
    for (int k = 0; k < TAPS; k++) acc += longint'(xl[k]) * longint'(act[k]);
    y = (acc + (longint'(1) << SH) / 2) >>> SH;
    e.sat = (y > hi) || (y < lo);
    e.val = int'(y > hi ? hi : y < lo ? lo : y);
    e.due = cyc + LAT;
    return e;
  endfunction

  task automatic sample();
    bit ev;
    ev = q.size() > 0 && q[0].due == cyc;
    chk("m_valid", m_valid, ev);
    if (ev) begin
      last = q[0].val;
      sat_m |= q[0].sat;
      void'(q.pop_front());
    end
    chk("m_data", $signed(m_data), last);
    chk("sat_flag", sat_flag, sat_m);
    chk("commit_busy", commit_busy, pend);
    cyc++;
  endtask

  task automatic step(bit v, int d = 0, bit we = 0, int addr = 0, int wd = 0, bit cm = 0, bit clr = 0);
    bit cp;
    @(negedge clk);
    rst_n = 1'b1; s_valid = v; s_data = 16'(d); coef_we = we; coef_addr = 6'(addr);
    coef_wdata = 16'(wd); coef_commit = cm; clear = clr;
    cp = pend && v;
    if (clr) begin
      xl = '{default: 0};
      q.delete();
      sat_m = 0;
      last = 0;
    end
    if (cp) act = shd;
    pend = !cp && (pend || cm);
    if (we && addr < TAPS) shd[addr] = wd;
    if (v && !clr) begin
      for (int k = TAPS - 1; k > 0; k--) xl[k] = xl[k-1];
      xl[0] = d;
      q.push_back(filt());
    end
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; coef_we = 1'b0; coef_commit = 1'b0; clear = 1'b0;
    q.delete();
    shd = '{default: 0}; act = '{default: 0}; xl = '{default: 0};
    pend = 0; sat_m = 0; last = 0;
    @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", $signed(m_data), 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_commit_busy", commit_busy, 0);
    cyc++;
  endtask

  task automatic load(int mode, int val);
    for (int k = 0; k < TAPS; k++)
      step(0, 0, 1, k, mode == 0 ? val : mode == 1 ? 2 * (k + 1) : (k == 0 ? val : 0));
    step(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    pulse_rst();
    step(0); step(0);
    load(1, 0);
    step(1, 16384);
    repeat (32) step(1, 0);
    repeat (LAT + 1) step(0);
    step(1, 16384);
    repeat (32) begin step(0); step(1, 0); end
    repeat (LAT + 1) step(0);
    load(0, 32767);
    repeat (33) step(1, 32767);
    repeat (LAT + 1) step(0);
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (33) step(1, -32768);
    repeat (LAT + 1) step(0);
    load(2, 16384);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 3); step(1, -3); step(1, 1);
    repeat (LAT + 1) step(0);
    load(0, 8192);
    repeat (40) step(1, 4);
    for (int k = 0; k < TAPS; k++) step(1, 4, 1, k, 16384);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 4, 1, 0, -5);
    repeat (40) step(1, 4);
    repeat (LAT + 1) step(0);
    repeat (900) begin
      int r;
      r = int'($urandom_range(0, 99));
      step($urandom_range(0, 2) != 0, int'($urandom_range(0, 65535)) - 32768, r < 30,
           int'($urandom_range(0, 40)), int'($urandom_range(0, 65535)) - 32768, r >= 30 && r < 34, r == 99);
    end
    step(1, 100); step(1, 200); step(1, 300);
    pulse_rst();
    repeat (LAT + 3) step(0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 1000);
    repeat (36) step(1, 0);
    repeat (LAT + 1) step(0);
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
